// File: rtl/periph_wr_arbiter.sv
// Round-robin arbiter that lets two requesters share the peripheral write bus.
// Writes outside the peripheral address window are acknowledged with err and never reach the bus.
module periph_wr_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int          WIN_BITS  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [31:0] addr0,
   input  logic [31:0] data0,
   output logic        ack0,
   output logic        err0,
   input  logic        req1,
   input  logic [31:0] addr1,
   input  logic [31:0] data1,
   output logic        ack1,
   output logic        err1,
   output logic        w_en,
   output logic [31:0] w_addr,
   output logic [31:0] w_data,
   output logic        last_gnt
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        grant_valid;
   logic        grant_idx;
   logic [31:0] sel_addr;
   logic [31:0] sel_data;
   logic        in_window;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Requests are only looked at in IDLE, so ISSUE always takes exactly one cycle.
   always_comb begin
      state_nxt   = state;
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               grant_valid = 1'b1;
               grant_idx   = ~last_gnt;
            end else if (req0) begin
               grant_valid = 1'b1;
               grant_idx   = 1'b0;
            end else if (req1) begin
               grant_valid = 1'b1;
               grant_idx   = 1'b1;
            end
            if (grant_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign sel_addr  = grant_idx ? addr1 : addr0;
   assign sel_data  = grant_idx ? data1 : data0;
   assign in_window = (sel_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);

   // Pulses are loaded on the grant edge and cleared on the next one, so they cover the ISSUE cycle only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_en     <= 1'b0;
         w_addr   <= 32'h0;
         w_data   <= 32'h0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         last_gnt <= 1'b1;
      end else begin
         w_en <= 1'b0;
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         if (grant_valid) begin
            w_addr   <= sel_addr;
            w_data   <= sel_data;
            last_gnt <= grant_idx;
            w_en     <= in_window;
            ack0     <= ~grant_idx;
            ack1     <= grant_idx;
            err0     <= ~grant_idx & ~in_window;
            err1     <= grant_idx & ~in_window;
         end
      end
   end

endmodule

// File: tb/tb_periph_wr_arbiter.sv
// Scoreboard bench for periph_wr_arbiter: a transaction-level model queues expected writes,
// and a negedge monitor pops and compares them whenever an ack appears.
module tb_periph_wr_arbiter;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam int          WIN  = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req0 = 1'b0;
   logic [31:0] addr0 = 32'h0;
   logic [31:0] data0 = 32'h0;
   logic        ack0;
   logic        err0;
   logic        req1 = 1'b0;
   logic [31:0] addr1 = 32'h0;
   logic [31:0] data1 = 32'h0;
   logic        ack1;
   logic        err1;
   logic        w_en;
   logic [31:0] w_addr;
   logic [31:0] w_data;
   logic        last_gnt;

   typedef struct {
      bit          idx;
      logic [31:0] addr;
      logic [31:0] data;
      bit          err;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   bit   m_last     = 1'b1;
   bit   m_busy     = 1'b0;

   periph_wr_arbiter #(.BASE_ADDR(BASE), .WIN_BITS(WIN)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0), .err0(err0),
      .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1), .err1(err1),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .last_gnt(last_gnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      check_output(name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a free arbiter grants one pending request, then needs one idle cycle before the next.
   initial begin
      exp_t e;
      bit   g;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_last = 1'b1;
            m_busy = 1'b0;
            exp_q.delete();
         end else if (m_busy) begin
            m_busy = 1'b0;
         end else if (req0 || req1) begin
            if (req0 && req1) g = !m_last;
            else              g = req1;
            e.idx  = g;
            e.addr = g ? addr1 : addr0;
            e.data = g ? data1 : data0;
            e.err  = (e.addr >> WIN) != (BASE >> WIN);
            e.cyc  = cyc;
            exp_q.push_back(e);
            m_last = g;
            m_busy = 1'b1;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check_bit("ack_exclusive", ack0 & ack1, 1'b0);
            if (ack0 || ack1) begin
               if (exp_q.size() == 0) begin
                  check_bit("unexpected_ack", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check_bit("ack_idx", ack1, e.idx);
                  check_bit("err", e.idx ? err1 : err0, e.err);
                  check_bit("err_other", e.idx ? err0 : err1, 1'b0);
                  check_bit("w_en", w_en, !e.err);
                  check_output("w_addr", w_addr, e.addr);
                  check_output("w_data", w_data, e.data);
                  check_output("latency", cyc, e.cyc);
               end
            end else begin
               check_output("quiet", {29'b0, w_en, err0, err1}, 32'h0);
            end
         end
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      m_last = 1'b1;
      m_busy = 1'b0;
      #1;
      check_output("rst_pulses", {27'b0, w_en, ack0, ack1, err0, err1}, 32'h0);
      check_output("rst_w_addr", w_addr, 32'h0);
      check_output("rst_w_data", w_data, 32'h0);
      check_bit("rst_last_gnt", last_gnt, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic apply_stimulus(input bit who, input int n);
      logic [31:0] a;
      bit          got;
      bit          keep;
      keep = 1'b0;
      for (int t = 0; t < n; t++) begin
         if (!keep) repeat ($urandom_range(0, 3)) step();
         case ($urandom_range(0, 4))
            0, 1:    a = BASE + ($urandom & 32'h3FF);
            2:       a = 32'h0000_07FC;
            3:       a = 32'h0000_03FC;
            default: a = $urandom;
         endcase
         if (who) begin req1 = 1'b1; addr1 = a; data1 = $urandom; end
         else     begin req0 = 1'b1; addr0 = a; data0 = $urandom; end
         got = 1'b0;
         for (int w = 0; w < 40 && !got; w++) begin
            step();
            got = who ? ack1 : ack0;
         end
         if (!got) check_bit("ack_timeout", 1'b0, 1'b1);
         keep = got && ($urandom_range(0, 1) == 1);
         if (!keep) begin
            if (who) req1 = 1'b0;
            else     req0 = 1'b0;
         end
      end
      if (who) req1 = 1'b0;
      else     req0 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int prev;
      bit got;
      #2;

      req0 = 1'b1; addr0 = 32'h400; data0 = 32'hA5;
      apply_reset();
      step();
      check_bit("t1_w_en", w_en, 1'b1);
      check_output("t1_w_addr", w_addr, 32'h400);
      check_output("t1_w_data", w_data, 32'hA5);
      check_output("t1_ack_err", {30'b0, ack0, err0}, 32'h2);
      check_bit("t1_last_gnt", last_gnt, 1'b0);
      req0 = 1'b0;
      step();

      req0 = 1'b1; addr0 = 32'h400; data0 = 32'h10;
      req1 = 1'b1; addr1 = 32'h404; data1 = 32'h11;
      apply_reset();
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k % 2 == 0)               check_output("t2_alt", {30'b0, ack1, ack0}, 32'h0);
         else if (((k - 1) / 2) % 2 == 0) check_output("t2_alt", {30'b0, ack1, ack0}, 32'h1);
         else                          check_output("t2_alt", {30'b0, ack1, ack0}, 32'h2);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) step();

      req1 = 1'b1; addr1 = 32'h800; data1 = 32'h5A5A;
      step();
      check_output("t3_ack_err", {30'b0, ack1, err1}, 32'h3);
      check_bit("t3_w_en", w_en, 1'b0);
      check_output("t3_w_addr", w_addr, 32'h800);
      addr1 = 32'h400;
      repeat (2) step();
      check_output("t3b_ack_err", {30'b0, ack1, err1}, 32'h2);
      check_bit("t3b_w_en", w_en, 1'b1);
      req1 = 1'b0;
      step();

      req0 = 1'b1; addr0 = 32'h410; data0 = 32'd1;
      prev = 0;
      for (int n = 0; n < 3; n++) begin
         got = 1'b0;
         for (int w = 0; w < 10 && !got; w++) begin
            step();
            got = ack0;
         end
         check_bit("t4_ack", got, 1'b1);
         check_output("t4_data", w_data, 32'(n + 1));
         if (n > 0) check_output("t4_spacing", 32'(cyc - prev), 32'd2);
         prev = cyc;
         data0 = 32'(n + 2);
         if (n == 2) req0 = 1'b0;
      end
      repeat (4) step();

      req0 = 1'b1; addr0 = 32'h420; data0 = 32'h77;
      step();
      check_bit("t5_w_en_before", w_en, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("t5_async_drop", {29'b0, w_en, ack0, ack1}, 32'h0);
      exp_q.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
      req0 = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_output("t5_no_stale", {29'b0, w_en, ack0, ack1}, 32'h0);
      end

      req1 = 1'b1; addr1 = 32'h404; data1 = 32'hBEEF;
      step();
      check_bit("t6_ack1", ack1, 1'b1);
      req1 = 1'b0;
      req0 = 1'b1; addr0 = 32'h408; data0 = 32'hDEAD;
      step();
      req0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_output("t6_ignored", {30'b0, ack0, w_en}, 32'h0);
      end

      fork
         apply_stimulus(1'b0, 25);
         apply_stimulus(1'b1, 25);
      join
      repeat (4) step();
      check_output("drain", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
